// File: rtl/bcd_display_scan_controller.sv
// Two-digit seven-segment scan controller: one shared BCD decoder alternates between
// the ones and tens digits, with blanking gaps and frame-aligned loading of new values.
module bcd_display_scan_controller #(
    parameter int unsigned REFRESH_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       Clk,
    input  logic       Reset_N,
    input  logic [7:0] BCD_Number,
    input  logic       Load,
    input  logic       Enable,
    input  logic       Zero_Blank,
    output logic [6:0] Segments,
    output logic [1:0] Digit_Enable,
    output logic       Load_Ack,
    output logic       Invalid
);

    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_ONES    = 3'd1;
    localparam logic [2:0] S_BLANK_A = 3'd2;
    localparam logic [2:0] S_TENS    = 3'd3;
    localparam logic [2:0] S_BLANK_B = 3'd4;

    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_disp;
    logic [7:0]       r_pend;
    logic             r_pend_v;
    logic [6:0]       r_seg;
    logic [1:0]       r_dig;
    logic             r_ack;

    logic [2:0]       w_nstate;
    logic             w_show_done;
    logic             w_blank_done;
    logic             w_apply;
    logic             w_ack;
    logic [7:0]       w_ndisp;
    logic [6:0]       w_nseg;
    logic [1:0]       w_ndig;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    assign w_show_done  = (r_cnt == REFRESH_LAST);
    assign w_blank_done = (r_cnt == BLANK_LAST);

    always_comb begin
        w_nstate = r_state;
        if (!Enable) begin
            w_nstate = S_OFF;
        end else begin
            case (r_state)
                S_OFF:     w_nstate = S_ONES;
                S_ONES:    if (w_show_done)  w_nstate = S_BLANK_A;
                S_BLANK_A: if (w_blank_done) w_nstate = S_TENS;
                S_TENS:    if (w_show_done)  w_nstate = S_BLANK_B;
                S_BLANK_B: if (w_blank_done) w_nstate = S_ONES;
                default:   w_nstate = S_OFF;
            endcase
        end
    end

    // Frame boundary: any edge entering SHOW_ONES; a Load on that same edge bypasses the pending register.
    assign w_apply = (w_nstate == S_ONES) && (r_state != S_ONES);
    assign w_ack   = w_apply && (Load || r_pend_v);

    always_comb begin
        w_ndisp = r_disp;
        if (w_apply) begin
            if (Load)
                w_ndisp = BCD_Number;
            else if (r_pend_v)
                w_ndisp = r_pend;
        end
    end

    always_comb begin
        w_nseg = '0;
        w_ndig = '0;
        case (w_nstate)
            S_ONES: begin
                w_ndig = 2'b01;
                w_nseg = f_decode(w_ndisp[3:0]);
            end
            S_TENS: begin
                w_ndig = 2'b10;
                if (!(Zero_Blank && (w_ndisp[7:4] == 4'd0)))
                    w_nseg = f_decode(w_ndisp[7:4]);
            end
            default: begin
                w_ndig = '0;
                w_nseg = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state  <= S_OFF;
            r_cnt    <= '0;
            r_disp   <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_seg    <= '0;
            r_dig    <= '0;
            r_ack    <= 1'b0;
        end else begin
            r_state <= w_nstate;
            if ((w_nstate != r_state) || (w_nstate == S_OFF))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            r_disp <= w_ndisp;
            if (w_apply) begin
                r_pend_v <= 1'b0;
            end else if (Load) begin
                r_pend_v <= 1'b1;
                r_pend   <= BCD_Number;
            end
            r_seg <= w_nseg;
            r_dig <= w_ndig;
            r_ack <= w_ack;
        end
    end

    assign Segments     = r_seg;
    assign Digit_Enable = r_dig;
    assign Load_Ack     = r_ack;
    assign Invalid      = (r_disp[7:4] > 4'd9) || (r_disp[3:0] > 4'd9);

endmodule

// File: tb/tb_bcd_display_scan_controller.sv
// Bench for bcd_display_scan_controller with REFRESH_CYCLES=4, BLANK_CYCLES=2 (12-cycle frame).
module tb_bcd_display_scan_controller;

    logic       Clk;
    logic       Reset_N;
    logic [7:0] BCD_Number;
    logic       Load;
    logic       Enable;
    logic       Zero_Blank;
    logic [6:0] Segments;
    logic [1:0] Digit_Enable;
    logic       Load_Ack;
    logic       Invalid;

    bcd_display_scan_controller #(
        .REFRESH_CYCLES(4),
        .BLANK_CYCLES  (2),
        .CNT_W         (4)
    ) dut (
        .Clk          (Clk),
        .Reset_N      (Reset_N),
        .BCD_Number   (BCD_Number),
        .Load         (Load),
        .Enable       (Enable),
        .Zero_Blank   (Zero_Blank),
        .Segments     (Segments),
        .Digit_Enable (Digit_Enable),
        .Load_Ack     (Load_Ack),
        .Invalid      (Invalid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0] de;
        logic [6:0] seg;
        logic       ack;
        logic       inv;
    } exp_t;

    typedef struct {
        logic       pre;
        logic [7:0] pre_bcd;
        logic [7:0] bcd;
        logic       zb;
        logic [6:0] ones;
        logic [6:0] tens;
        logic       inv;
    } vec_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference state: frame position of the next output cycle, displayed and pending values
    int         m_pos  = 0;
    logic       m_on   = 1'b0;
    logic [7:0] m_disp = 8'h00;
    logic [7:0] m_pend = 8'h00;
    logic       m_pend_v = 1'b0;
    logic       zb     = 1'b0;
    logic       rstn   = 1'b0;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000001;
        endcase
    endfunction

    function automatic logic inv_of(input logic [7:0] v);
        return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    endfunction

    always begin
        exp_t e;
        @(posedge Clk);
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            n_assert++;
            if ({Digit_Enable, Segments, Load_Ack, Invalid} !== {e.de, e.seg, e.ack, e.inv}) begin
                n_fail++;
                $display("FAIL cycle @%0t: got de=%b seg=%b ack=%b inv=%b, expected de=%b seg=%b ack=%b inv=%b",
                         $time, Digit_Enable, Segments, Load_Ack, Invalid, e.de, e.seg, e.ack, e.inv);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one clock cycle of inputs and push the expected registered outputs after the next edge
    task automatic tick(input logic en, input logic ld, input logic [7:0] bcd);
        exp_t e;
        Enable     = en;
        Load       = ld;
        BCD_Number = bcd;
        Zero_Blank = zb;
        Reset_N    = rstn;
        e = '{de: 2'b00, seg: 7'h00, ack: 1'b0, inv: 1'b0};
        if (!rstn) begin
            m_disp   = 8'h00;
            m_pend_v = 1'b0;
            m_on     = 1'b0;
        end else if (!en) begin
            if (ld) begin
                m_pend   = bcd;
                m_pend_v = 1'b1;
            end
            m_on  = 1'b0;
            e.inv = inv_of(m_disp);
        end else begin
            if (!m_on) m_pos = 0;
            if (m_pos == 0) begin
                if (ld) begin
                    m_disp = bcd;
                    e.ack  = 1'b1;
                end else if (m_pend_v) begin
                    m_disp = m_pend;
                    e.ack  = 1'b1;
                end
                m_pend_v = 1'b0;
            end else if (ld) begin
                m_pend   = bcd;
                m_pend_v = 1'b1;
            end
            if (m_pos < 4) begin
                e.de  = 2'b01;
                e.seg = seg_of(m_disp[3:0]);
            end else if (m_pos >= 6 && m_pos < 10) begin
                e.de  = 2'b10;
                e.seg = (zb && m_disp[7:4] == 4'd0) ? 7'h00 : seg_of(m_disp[7:4]);
            end
            e.inv = inv_of(m_disp);
            m_pos = (m_pos + 1) % 12;
            m_on  = 1'b1;
        end
        q.push_back(e);
        @(negedge Clk);
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 24 && m_pos != target; k++)
            tick(1'b1, 1'b0, 8'h00);
    endtask

    vec_t vt[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{pre: 1'b0, pre_bcd: 8'h00, bcd: 8'h24, zb: 1'b0, ones: 7'b0110011, tens: 7'b1101101, inv: 1'b0};
        vt[1] = '{pre: 1'b1, pre_bcd: 8'h99, bcd: 8'h37, zb: 1'b0, ones: 7'b1110000, tens: 7'b1111001, inv: 1'b0};
        vt[2] = '{pre: 1'b0, pre_bcd: 8'h00, bcd: 8'h05, zb: 1'b1, ones: 7'b1011011, tens: 7'b0000000, inv: 1'b0};
        vt[3] = '{pre: 1'b0, pre_bcd: 8'h00, bcd: 8'h05, zb: 1'b0, ones: 7'b1011011, tens: 7'b1111110, inv: 1'b0};
        vt[4] = '{pre: 1'b0, pre_bcd: 8'h00, bcd: 8'hA3, zb: 1'b0, ones: 7'b1111001, tens: 7'b0000001, inv: 1'b1};
        vt[5] = '{pre: 1'b0, pre_bcd: 8'h00, bcd: 8'h12, zb: 1'b0, ones: 7'b1101101, tens: 7'b0110000, inv: 1'b0};

        Reset_N    = 1'b0;
        Enable     = 1'b1;
        Load       = 1'b0;
        BCD_Number = 8'h00;
        Zero_Blank = 1'b0;
        @(negedge Clk);

        // Reset state
        rstn = 1'b0;
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        chk("reset_seg", {1'b0, Segments}, 8'h00);
        chk("reset_de_ack_inv", {5'b0, Digit_Enable, Load_Ack | Invalid}, 8'h00);

        // Free-running scan of 8'h00 after release
        rstn = 1'b1;
        for (int i = 0; i < 24; i++) tick(1'b1, 1'b0, 8'h00);

        // Table: load mid-SHOW_TENS, then check the following frame
        foreach (vt[i]) begin
            zb = vt[i].zb;
            run_to(7);
            if (vt[i].pre) begin
                tick(1'b1, 1'b1, vt[i].pre_bcd);
                tick(1'b1, 1'b0, 8'h00);
                tick(1'b1, 1'b1, vt[i].bcd);
            end else begin
                tick(1'b1, 1'b1, vt[i].bcd);
            end
            run_to(0);
            tick(1'b1, 1'b0, 8'h00);
            chk("vec_ack", {7'b0, Load_Ack}, 8'h01);
            chk("vec_ones_seg", {1'b0, Segments}, {1'b0, vt[i].ones});
            chk("vec_invalid", {7'b0, Invalid}, {7'b0, vt[i].inv});
            run_to(7);
            chk("vec_tens_de", {6'b0, Digit_Enable}, 8'h02);
            chk("vec_tens_seg", {1'b0, Segments}, {1'b0, vt[i].tens});
            run_to(0);
        end

        // Disable mid-SHOW_ONES, load while off, re-enable
        zb = 1'b0;
        run_to(2);
        tick(1'b0, 1'b0, 8'h00);
        chk("off_de_seg", {Digit_Enable != 2'b00, Segments}, 8'h00);
        tick(1'b0, 1'b1, 8'h81);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00);
        chk("off_invalid_kept", {7'b0, Invalid}, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        chk("reenable_ack", {7'b0, Load_Ack}, 8'h01);
        chk("reenable_ones", {1'b0, Segments}, {1'b0, 7'b0110000});
        run_to(7);
        chk("reenable_tens", {1'b0, Segments}, {1'b0, 7'b1111111});
        run_to(0);

        // Asynchronous reset mid-frame with a value pending
        run_to(3);
        tick(1'b1, 1'b1, 8'hA5);
        run_to(6);
        rstn    = 1'b0;
        Reset_N = 1'b0;
        #1;
        chk("async_reset_seg", {1'b0, Segments}, 8'h00);
        chk("async_reset_de_ack", {6'b0, Digit_Enable}, {7'b0, Load_Ack});
        chk("async_reset_ack", {7'b0, Load_Ack}, 8'h00);
        chk("async_reset_inv", {7'b0, Invalid}, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        rstn = 1'b1;
        tick(1'b1, 1'b0, 8'h00);
        chk("post_reset_no_ack", {7'b0, Load_Ack}, 8'h00);
        chk("post_reset_ones", {1'b0, Segments}, {1'b0, 7'b1111110});
        run_to(7);
        chk("post_reset_tens", {1'b0, Segments}, {1'b0, 7'b1111110});
        run_to(0);
        tick(1'b1, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan_controller.md
Name: bcd_display_scan_controller

Overview:
- Time-multiplexed scan controller for a two-digit common-cathode seven-segment display.
- Holds a two-digit packed BCD value and alternates one shared BCD-to-segment decode path between the ones digit and the tens digit.
- Inserts blanking gaps between digits to suppress ghosting.
- Loads new values only at frame boundaries, so a frame never shows a mix of old and new digits.
- Sits between the counter/arithmetic logic that produces BCD values and the board display pins.

Parameters:
- REFRESH_CYCLES, 50000: clock cycles each digit is driven per visit. Minimum 1.
- BLANK_CYCLES, 16: clock cycles with all digits off after each digit visit. Minimum 1.
- CNT_W, 16: width of the dwell counter. Must hold max(REFRESH_CYCLES, BLANK_CYCLES) - 1.

Ports:
- Clk, input, 1: system clock, rising edge.
- Reset_N, input, 1: asynchronous active-low reset.
- BCD_Number, input, 8: packed BCD. [7:4] is tens, [3:0] is ones.
- Load, input, 1: request to display BCD_Number. Sampled on each rising edge.
- Enable, input, 1: 1 = scanning, 0 = display off.
- Zero_Blank, input, 1: 1 = blank the tens digit when tens = 0.
- Segments, output, 7: {a,b,c,d,e,f,g}, active-high, bit 6 = a.
- Digit_Enable, output, 2: [1] = tens, [0] = ones. Active-high, never both set.
- Load_Ack, output, 1: one-cycle pulse when a loaded value becomes the displayed value.
- Invalid, output, 1: displayed value contains a nibble greater than 9.

Behaviour:
- Reset (asynchronous, Reset_N = 0):
  - State = OFF. Displayed register = 8'h00. Pending flag and pending register cleared. Dwell counter = 0.
  - All outputs 0.
  - Reset mid-frame or mid-pending aborts everything; the pending value is lost.
- Outputs: all registered, updating on the Clk edge of each state change.
- States:
  - OFF: Digit_Enable = 00, Segments = 0.
  - SHOW_ONES: Digit_Enable = 01, Segments = decode(ones).
  - BLANK_A: Digit_Enable = 00, Segments = 0.
  - SHOW_TENS: Digit_Enable = 10, Segments = decode(tens), or 0 when Zero_Blank = 1 and tens = 0.
  - BLANK_B: Digit_Enable = 00, Segments = 0.
- Transitions:
  - OFF -> SHOW_ONES on the first edge where Enable = 1.
  - SHOW states last exactly REFRESH_CYCLES cycles.
  - BLANK states last exactly BLANK_CYCLES cycles.
  - Order: SHOW_ONES -> BLANK_A -> SHOW_TENS -> BLANK_B -> SHOW_ONES.
  - Frame length = 2*(REFRESH_CYCLES + BLANK_CYCLES) cycles.
  - Dwell counter resets to 0 on every state entry.
- Enable = 0 in any state: go to OFF on the next edge. Displayed value and pending state are kept. Re-enable restarts the frame at SHOW_ONES.
- Decode table (active-high, {a..g}):
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - nibble 10..15 = 0000001 (dash)
- Load handling:
  - Load = 1 sets pending and captures BCD_Number into the pending register. A later Load before the apply point overwrites it (newest wins, single Load_Ack).
  - Apply point = the edge that enters SHOW_ONES, either from BLANK_B or from OFF. At that edge: pending value -> displayed register, pending cleared, Load_Ack = 1 for that cycle.
  - If Load = 1 on the apply edge itself, the BCD_Number present on that edge is the value applied.
  - Load while Enable = 0: value stays pending and is applied when scanning resumes.
- Invalid:
  - Combinational from the displayed register: 1 if either nibble > 9.
  - Evaluated regardless of Zero_Blank.
  - Valid while OFF.

Test Plan:
1. Reset release with REFRESH_CYCLES = 4, BLANK_CYCLES = 2, Enable = 1, no Load.
   -> Pattern repeats every 12 cycles: 4 cycles Digit_Enable = 01 with Segments = 1111110; 2 cycles 00; 4 cycles 10 with 1111110; 2 cycles 00.
2. Load pulse with BCD_Number = 8'h24 mid-SHOW_TENS.
   -> Current frame still shows the old value. Load_Ack pulses on the next SHOW_ONES entry. Ones phase = 0110011, tens phase = 1101101.
3. Load 8'h99, then Load 8'h37 two cycles later, both within one frame.
   -> Exactly one Load_Ack. Next frame shows ones = 1110000, tens = 1111001.
4. Load 8'h05 with Zero_Blank = 1.
   -> Ones phase = 1011011. Tens phase: Digit_Enable = 10 with Segments = 0000000. Repeat with Zero_Blank = 0 -> tens phase = 1111110.
5. Load 8'hA3.
   -> Invalid = 1. Tens phase = 0000001, ones phase = 1111001. Load 8'h12 -> Invalid = 0 after its Load_Ack.
6. Enable = 0 mid-SHOW_ONES, Load 8'h81 while off, Reset_N pulsed low during a later frame.
   -> Outputs 0 one edge after Enable drops. On re-enable, Load_Ack fires on the SHOW_ONES entry and 8'h81 is displayed. On reset, all outputs go to 0 immediately and the displayed value is 8'h00 afterwards.
